packet_injector: RTL
====================

Name: packet_injector

Overview:
- Transmit-side network interface: takes payload words and a send command from a host/IP, serializes them into flits, and drives them into one local switch port using the wr/r ready handshake.
- Sits between a traffic source and the switch local port, in place of the sending half of fabric.
- Buffers one or more packets of payload in an internal FIFO and enforces the configured inter-flit and inter-packet gaps.
- Counts sent packets so benches can compare against the receiver-side recv_packs totals.

Parameters:
DATA_SIZE, 8, payload bits per flit
ADDR_SIZE, 4, destination address bits
ADDR, 0, own node address (informational; self-send allowed)
NODES_NUM, 16, valid destinations 0..NODES_NUM-1
MEM_LOG2, 3, payload FIFO depth = 2^MEM_LOG2 words
FLIT_DELAY, 0, idle cycles forced after each non-tail flit
PACK_DELAY, 0, idle cycles forced after each tail flit
(derived) FLIT_SIZE = DATA_SIZE+ADDR_SIZE+1

Ports:
clk  in  1  clock, all state on rising edge
a_rst  in  1  asynchronous reset, active-low
pay_wr_i  in  1  push pay_data_i into FIFO
pay_data_i  in  DATA_SIZE  payload word
pay_full_o  out  1  FIFO full
pay_cnt_o  out  MEM_LOG2+1  FIFO occupancy
cmd_valid_i  in  1  send request
cmd_dest_i  in  ADDR_SIZE  destination node
cmd_len_i  in  MEM_LOG2+1  packet length in flits
cmd_ready_o  out  1  command can be accepted
cmd_err_o  out  1  one-cycle pulse: command rejected
ovf_o  out  1  sticky: write attempted while full
data_o  out  FLIT_SIZE  flit to switch
wr_ready_out  out  1  flit on data_o valid
r_ready_in  in  1  switch can accept a flit
busy_o  out  1  state != IDLE
sent_packs_o  out  32  tail flits transferred

Behaviour:
- Reset: a_rst=0 asynchronously clears FIFO, counters, and FSM. Reset values: data_o=0, wr_ready_out=0, cmd_ready_o=0, cmd_err_o=0, ovf_o=0, busy_o=0, sent_packs_o=0, pay_cnt_o=0, pay_full_o=0. cmd_ready_o rises the first cycle after release.
- Reset mid-packet: the partial packet is abandoned with no tail emitted, and the FIFO is emptied.
- Flit format: data_o[FLIT_SIZE-1]=tail; data_o[FLIT_SIZE-2 -: ADDR_SIZE]=dest; data_o[DATA_SIZE-1:0]=word. Every flit carries the dest. Tail=1 only on the last flit.
- Handshake: a transfer occurs at a rising edge with wr_ready_out=1 and r_ready_in=1. While wr_ready_out=1 and r_ready_in=0, data_o and wr_ready_out hold stable. data_o=0 whenever wr_ready_out=0.
- FIFO:
  - Write accepted when pay_wr_i=1 and pay_cnt_o<2^MEM_LOG2. Full is judged on the pre-edge count, so a write while full is dropped and sets ovf_o even if a pop occurs in the same cycle.
  - Simultaneous write and pop: both occur and the count is unchanged.
  - FIFO is show-ahead; the head feeds data_o.
- FSM IDLE -> SEND -> GAP -> IDLE:
  - IDLE:
    - cmd_ready_o=1.
    - On cmd_valid_i with 1<=cmd_len_i<=2^MEM_LOG2 and cmd_dest_i<NODES_NUM: latch dest and len, go to SEND.
    - Otherwise, if cmd_valid_i: pulse cmd_err_o for one cycle and stay in IDLE.
  - SEND:
    - wr_ready_out = (FIFO nonempty) and (flit-gap counter==0).
    - An empty FIFO stalls transmission with no error; sending resumes the cycle after a word is written.
    - Each transfer pops the FIFO and decrements the remaining count.
    - After a non-tail transfer, load the flit-gap counter with FLIT_DELAY.
    - After the tail transfer: sent_packs_o+1 (wraps at 2^32), load the packet-gap counter with PACK_DELAY, go to GAP.
  - GAP: count down the packet-gap counter; go to IDLE when it reads 0. With PACK_DELAY=0, GAP lasts exactly one cycle.
- Latency: a command accepted at edge N with the FIFO nonempty gives wr_ready_out=1 from edge N+1. Minimum command-to-command spacing is len+2+PACK_DELAY cycles with r_ready_in held at 1.
- cmd_ready_o=0 in SEND and GAP; commands presented then are ignored with no error.
- Payload may be written in any state, including ahead of the command.

Test Plan:
- Reset release, write 3 words 0x11,0x22,0x33, cmd dest=5 len=3, r_ready_in=1 -> flits 0x0511,0x0522,0x1533 (tail bit 12) on 3 consecutive cycles from N+1; sent_packs_o=1; cmd_ready_o returns 1 two cycles after the tail.
- Same packet with r_ready_in=0 for 4 cycles at the 2nd flit -> data_o held at 0x0522 and wr_ready_out=1 throughout; 3 transfers total, no duplicates.
- FLIT_DELAY=2, PACK_DELAY=3, two back-to-back len=2 commands -> exactly 2 idle cycles between intra-packet flits and 3+1 cycles of GAP before the next cmd_ready_o; sent_packs_o=2.
- cmd len=0, then dest=16 (NODES_NUM=16) -> one cmd_err_o pulse each, no flits, busy_o stays 0.
- Write 9 words into a depth-8 FIFO -> pay_full_o=1 after the 8th, ovf_o=1, pay_cnt_o=8.
- cmd len=4 with 1 word buffered -> 1 flit sent, then stall with wr_ready_out=0. Write 3 words -> remaining 3 flits sent. Assert a_rst=0 mid-packet on a second run -> all outputs 0 immediately, no tail, sent_packs_o=0.

Source files
------------

// File: rtl/packet_injector.sv
// Transmit-side network interface: buffers payload words in a show-ahead FIFO
// and serialises them as addressed flits into one switch port (wr/r handshake).
module packet_injector #(
    parameter int DATA_SIZE  = 8,
    parameter int ADDR_SIZE  = 4,
    parameter int ADDR       = 0,
    parameter int NODES_NUM  = 16,
    parameter int MEM_LOG2   = 3,
    parameter int FLIT_DELAY = 0,
    parameter int PACK_DELAY = 0
) (
    input  logic                           clk,
    input  logic                           a_rst,
    input  logic                           pay_wr_i,
    input  logic [DATA_SIZE-1:0]           pay_data_i,
    output logic                           pay_full_o,
    output logic [MEM_LOG2:0]              pay_cnt_o,
    input  logic                           cmd_valid_i,
    input  logic [ADDR_SIZE-1:0]           cmd_dest_i,
    input  logic [MEM_LOG2:0]              cmd_len_i,
    output logic                           cmd_ready_o,
    output logic                           cmd_err_o,
    output logic                           ovf_o,
    output logic [DATA_SIZE+ADDR_SIZE:0]   data_o,
    output logic                           wr_ready_out,
    input  logic                           r_ready_in,
    output logic                           busy_o,
    output logic [31:0]                    sent_packs_o
);

    localparam int DEPTH = 2 ** MEM_LOG2;
    localparam int CW    = MEM_LOG2 + 1;
    localparam int FGW   = (FLIT_DELAY > 0) ? $clog2(FLIT_DELAY + 1) : 1;
    localparam int PGW   = (PACK_DELAY > 0) ? $clog2(PACK_DELAY + 1) : 1;

    // The own address only has to name a real node; self-send is legal.
    generate
        if (ADDR >= NODES_NUM) begin : g_addr_check
            $error("packet_injector: ADDR outside 0..NODES_NUM-1");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    state_t                 state_reg, state_next;
    logic                   started_reg;
    logic [ADDR_SIZE-1:0]   dest_reg;
    logic [CW-1:0]          rem_reg;
    logic [FGW-1:0]         fgap_reg;
    logic [PGW-1:0]         pgap_reg;
    logic [31:0]            sent_reg;
    logic                   ovf_reg;

    logic [DATA_SIZE-1:0]   mem [DEPTH];
    logic [MEM_LOG2-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]          cnt_reg;

    logic fifo_full, fifo_empty, push, pop;
    logic cmd_legal, accept, tail;

    assign fifo_full  = (cnt_reg == CW'(DEPTH));
    assign fifo_empty = (cnt_reg == '0);
    assign push       = pay_wr_i && !fifo_full;
    assign pop        = wr_ready_out && r_ready_in;
    assign tail       = (rem_reg == CW'(1));

    assign cmd_legal = (cmd_len_i != '0) && (cmd_len_i <= CW'(DEPTH))
                       && (32'(cmd_dest_i) < NODES_NUM);
    assign accept    = (state_reg == S_IDLE) && started_reg && cmd_valid_i && cmd_legal;

    // Payload storage carries no reset; emptiness is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= pay_data_i;
        end
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            cnt_reg    <= '0;
            ovf_reg    <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      cnt_reg <= cnt_reg + CW'(1);
            else if (!push && pop) cnt_reg <= cnt_reg - CW'(1);
            if (pay_wr_i && fifo_full) ovf_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept) state_next = S_SEND;
            S_SEND:  if (pop && tail) state_next = S_GAP;
            S_GAP:   if (pgap_reg == '0) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready_o  = (state_reg == S_IDLE) && started_reg;
        cmd_err_o    = (state_reg == S_IDLE) && started_reg && cmd_valid_i && !cmd_legal;
        busy_o       = (state_reg != S_IDLE);
        wr_ready_out = (state_reg == S_SEND) && !fifo_empty && (fgap_reg == '0);
        data_o       = '0;
        if (wr_ready_out) begin
            data_o = {tail, dest_reg, mem[rd_ptr_reg]};
        end
    end

    // started_reg holds cmd_ready_o low for the first cycle out of reset.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            started_reg <= 1'b0;
            dest_reg    <= '0;
            rem_reg     <= '0;
            fgap_reg    <= '0;
            pgap_reg    <= '0;
            sent_reg    <= '0;
        end else begin
            started_reg <= 1'b1;
            if (accept) begin
                dest_reg <= cmd_dest_i;
                rem_reg  <= cmd_len_i;
                fgap_reg <= '0;
            end
            if (state_reg == S_SEND) begin
                if (pop) begin
                    rem_reg <= rem_reg - CW'(1);
                    if (tail) begin
                        sent_reg <= sent_reg + 32'd1;
                        pgap_reg <= PGW'(PACK_DELAY);
                    end else begin
                        fgap_reg <= FGW'(FLIT_DELAY);
                    end
                end else if (fgap_reg != '0) begin
                    fgap_reg <= fgap_reg - FGW'(1);
                end
            end
            if (state_reg == S_GAP && pgap_reg != '0) begin
                pgap_reg <= pgap_reg - PGW'(1);
            end
        end
    end

    assign pay_full_o   = fifo_full;
    assign pay_cnt_o    = cnt_reg;
    assign ovf_o        = ovf_reg;
    assign sent_packs_o = sent_reg;

endmodule
